// File: rtl/s3g_rx_pp.sv
// rtl/s3g_rx_pp.sv - framed byte receiver (D5/LEN/payload/CRC8) into a ping-pong packet buffer; optional idle timeout under S3G_RX_TIMEOUT_EN
module s3g_rx_pp #(
    parameter int MAX_LEN     = 32,
    parameter int SHADOW_N    = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  buffer_release,
    input  logic [7:0]            buffer_addr,
    output logic [7:0]            buffer_data,
    output logic                  packet_done,
    output logic                  packet_error,
    output logic                  packet_overrun,
    output logic                  buffer_valid,
    output logic [7:0]            payload_len,
    output logic [1:0]            error_code,
    output logic                  busy,
    output logic [SHADOW_N*8-1:0] shadow
);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CRC} state_t;

    localparam logic [8:0] ML9 = 9'(MAX_LEN);

    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            waddr_q, waddr_d;
    logic [7:0]            crc_q, crc_d;
    logic                  bank_q, bank_d;      // bank currently owned by the host
    logic                  valid_q, valid_d;
    logic [7:0]            plen_q, plen_d;
    logic [SHADOW_N*8-1:0] shadow_q, shadow_d;
    logic [SHADOW_N*8-1:0] stage_q, stage_d;
    logic [1:0]            ecode_q, ecode_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic [7:0]            rdata_q, rdata_d;

    logic                  we;
    logic [8:0]            wr_idx;
    logic [8:0]            rd_idx;
    logic [7:0]            mem [0:2*MAX_LEN-1];

`ifdef S3G_RX_TIMEOUT_EN
    logic [31:0]           timer_q, timer_d;
`else
    logic                  unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Dallas/iButton CRC8, reflected polynomial 0x8C, one byte at a time
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        end
        return r;
    endfunction

    assign wr_idx = (bank_q ? 9'd0 : ML9) + {1'b0, waddr_q};
    assign rd_idx = (bank_q ? ML9 : 9'd0) + {1'b0, buffer_addr};

    // Frame FSM, bank handover and host read mux
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        waddr_d  = waddr_q;
        crc_d    = crc_q;
        bank_d   = bank_q;
        valid_d  = valid_q;
        plen_d   = plen_q;
        shadow_d = shadow_q;
        stage_d  = stage_q;
        ecode_d  = ecode_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        we       = 1'b0;
        rdata_d  = 8'h00;
`ifdef S3G_RX_TIMEOUT_EN
        timer_d  = 32'd0;
`endif

        if (buffer_release) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_done && rx_data == 8'hD5) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_done) begin
                    len_d   = rx_data;
                    crc_d   = 8'h00;
                    waddr_d = 8'd0;
                    stage_d = '0;
                    if (rx_data == 8'd0) begin
                        state_d = S_CRC;
                    end else if (rx_data <= 8'(MAX_LEN)) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        ecode_d = 2'd2;
                    end
                end
            end
            S_DATA: begin
                if (rx_done) begin
                    we      = 1'b1;
                    crc_d   = crc8_upd(crc_q, rx_data);
                    waddr_d = waddr_q + 8'd1;
                    for (int i = 0; i < SHADOW_N; i++) begin
                        if (waddr_q == 8'(i)) begin
                            stage_d[i*8 +: 8] = rx_data;
                        end
                    end
                    if (waddr_q == len_q - 8'd1) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (rx_done) begin
                    state_d = S_IDLE;
                    if (rx_data == crc_q) begin
                        if (!valid_q || buffer_release) begin
                            bank_d   = ~bank_q;
                            plen_d   = len_q;
                            shadow_d = stage_q;
                            valid_d  = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            ovr_d    = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef S3G_RX_TIMEOUT_EN
        if (state_q != S_IDLE && !rx_done) begin
            timer_d = timer_q + 32'd1;
            if (timer_q == 32'(TIMEOUT_CYC - 1)) begin
                timer_d = 32'd0;
                state_d = S_IDLE;
                err_d   = 1'b1;
                ecode_d = 2'd3;
            end
        end
`endif

        if ({1'b0, buffer_addr} < ML9) begin
            rdata_d = mem[rd_idx];
        end
    end

    // Control and output registers; the bank RAM is deliberately outside the reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= 8'd0;
            waddr_q  <= 8'd0;
            crc_q    <= 8'h00;
            bank_q   <= 1'b0;
            valid_q  <= 1'b0;
            plen_q   <= 8'd0;
            shadow_q <= '0;
            stage_q  <= '0;
            ecode_q  <= 2'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            rdata_q  <= 8'h00;
`ifdef S3G_RX_TIMEOUT_EN
            timer_q  <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            waddr_q  <= waddr_d;
            crc_q    <= crc_d;
            bank_q   <= bank_d;
            valid_q  <= valid_d;
            plen_q   <= plen_d;
            shadow_q <= shadow_d;
            stage_q  <= stage_d;
            ecode_q  <= ecode_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            rdata_q  <= rdata_d;
`ifdef S3G_RX_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // Payload write into the bank not held by the host
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= rx_data;
        end
    end

    assign buffer_data    = rdata_q;
    assign packet_done    = done_q;
    assign packet_error   = err_q;
    assign packet_overrun = ovr_q;
    assign buffer_valid   = valid_q;
    assign payload_len    = plen_q;
    assign error_code     = ecode_q;
    assign busy           = (state_q != S_IDLE);
    assign shadow         = shadow_q;

endmodule

// File: tb/tb_s3g_rx_pp.sv
// tb/tb_s3g_rx_pp.sv - directed self-checking bench for s3g_rx_pp
module tb_s3g_rx_pp;

    localparam int MAX_LEN     = 32;
    localparam int SHADOW_N    = 16;
    localparam int TIMEOUT_CYC = 100;

    logic                  clk;
    logic                  rst_n;
    logic [7:0]            rx_data;
    logic                  rx_done;
    logic                  buffer_release;
    logic [7:0]            buffer_addr;
    logic [7:0]            buffer_data;
    logic                  packet_done;
    logic                  packet_error;
    logic                  packet_overrun;
    logic                  buffer_valid;
    logic [7:0]            payload_len;
    logic [1:0]            error_code;
    logic                  busy;
    logic [SHADOW_N*8-1:0] shadow;

    int n_vec;
    int n_err;

    s3g_rx_pp #(
        .MAX_LEN    (MAX_LEN),
        .SHADOW_N   (SHADOW_N),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .buffer_release(buffer_release),
        .buffer_addr   (buffer_addr),
        .buffer_data   (buffer_data),
        .packet_done   (packet_done),
        .packet_error  (packet_error),
        .packet_overrun(packet_overrun),
        .buffer_valid  (buffer_valid),
        .payload_len   (payload_len),
        .error_code    (error_code),
        .busy          (busy),
        .shadow        (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b, input logic rel);
        @(negedge clk);
        rx_data        = b;
        rx_done        = 1'b1;
        buffer_release = rel;
        @(negedge clk);
        rx_done        = 1'b0;
        buffer_release = 1'b0;
    endtask

    task automatic release_host();
        @(negedge clk);
        buffer_release = 1'b1;
        @(negedge clk);
        buffer_release = 1'b0;
    endtask

    task automatic read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        buffer_addr = a;
        @(negedge clk);
        d = buffer_data;
    endtask

    task automatic test_reset();
        n_vec++;
        if (busy !== 1'b0 || buffer_valid !== 1'b0 || payload_len !== 8'd0 ||
            error_code !== 2'd0 || buffer_data !== 8'h00 || shadow !== '0) begin
            n_err++;
            $display("FAIL reset_state busy=%0b valid=%0b len=%0d ecode=%0d data=%h want all zero",
                     busy, buffer_valid, payload_len, error_code, buffer_data);
        end
        n_vec++;
        if (packet_done !== 1'b0 || packet_error !== 1'b0 || packet_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses got %0b%0b%0b want 000", packet_done, packet_error, packet_overrun);
        end
    endtask

    task automatic test_good_one();
        logic [7:0] d;
        send(8'hD5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h5E, 0);
        n_vec++;
        if (packet_done !== 1'b1 || packet_error !== 1'b0) begin
            n_err++; $display("FAIL good1_done got done=%0b err=%0b want 1/0", packet_done, packet_error);
        end
        n_vec++;
        if (payload_len !== 8'd1 || buffer_valid !== 1'b1) begin
            n_err++; $display("FAIL good1_len got len=%0d valid=%0b want 1/1", payload_len, buffer_valid);
        end
        n_vec++;
        if (shadow[7:0] !== 8'h01) begin
            n_err++; $display("FAIL good1_shadow got %h want 01", shadow[7:0]);
        end
        read(8'd0, d);
        n_vec++;
        if (d !== 8'h01) begin
            n_err++; $display("FAIL good1_read0 got %h want 01", d);
        end
        release_host();
        n_vec++;
        if (buffer_valid !== 1'b0 || payload_len !== 8'd1 || shadow[7:0] !== 8'h01) begin
            n_err++; $display("FAIL release_hold got valid=%0b len=%0d sh=%h want 0/1/01",
                              buffer_valid, payload_len, shadow[7:0]);
        end
    endtask

    task automatic test_zero_len();
        send(8'hD5, 0); send(8'h00, 0); send(8'h00, 0);
        n_vec++;
        if (packet_done !== 1'b1) begin
            n_err++; $display("FAIL zero_done got %0b want 1", packet_done);
        end
        n_vec++;
        if (payload_len !== 8'd0 || shadow !== '0) begin
            n_err++; $display("FAIL zero_len got len=%0d sh_lo=%h want 0/0", payload_len, shadow[7:0]);
        end
        release_host();
    endtask

    task automatic test_crc_error();
        send(8'hD5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h5F, 0);
        n_vec++;
        if (packet_error !== 1'b1 || packet_done !== 1'b0) begin
            n_err++; $display("FAIL crc_err_pulse got err=%0b done=%0b want 1/0", packet_error, packet_done);
        end
        n_vec++;
        if (error_code !== 2'd1 || buffer_valid !== 1'b0) begin
            n_err++; $display("FAIL crc_err_code got code=%0d valid=%0b want 1/0", error_code, buffer_valid);
        end
    endtask

    task automatic test_len_error();
        send(8'hD5, 0); send(8'h21, 0);
        n_vec++;
        if (packet_error !== 1'b1 || error_code !== 2'd2 || busy !== 1'b0) begin
            n_err++; $display("FAIL len_err got err=%0b code=%0d busy=%0b want 1/2/0",
                              packet_error, error_code, busy);
        end
        send(8'hD5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h5E, 0);
        n_vec++;
        if (packet_done !== 1'b1) begin
            n_err++; $display("FAIL len_err_next got done=%0b want 1", packet_done);
        end
        n_vec++;
        if (error_code !== 2'd2) begin
            n_err++; $display("FAIL ecode_hold got %0d want 2", error_code);
        end
        release_host();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        send(8'hD5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h5E, 0);
        n_vec++;
        if (packet_done !== 1'b1 || buffer_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_first got done=%0b valid=%0b want 1/1", packet_done, buffer_valid);
        end
        send(8'hD5, 0); send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h78, 0);
        n_vec++;
        if (packet_overrun !== 1'b1 || packet_done !== 1'b0) begin
            n_err++; $display("FAIL overrun_pulse got ovr=%0b done=%0b want 1/0", packet_overrun, packet_done);
        end
        n_vec++;
        if (payload_len !== 8'd1 || shadow[15:0] !== 16'h0001) begin
            n_err++; $display("FAIL overrun_keep got len=%0d sh=%h want 1/0001", payload_len, shadow[15:0]);
        end
        read(8'd0, d);
        n_vec++;
        if (d !== 8'h01) begin
            n_err++; $display("FAIL overrun_read0 got %h want 01", d);
        end
        send(8'hD5, 0); send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h78, 1);
        n_vec++;
        if (packet_done !== 1'b1 || buffer_valid !== 1'b1 || packet_overrun !== 1'b0) begin
            n_err++; $display("FAIL rel_swap got done=%0b valid=%0b ovr=%0b want 1/1/0",
                              packet_done, buffer_valid, packet_overrun);
        end
        n_vec++;
        if (payload_len !== 8'd2 || shadow[15:0] !== 16'h0201) begin
            n_err++; $display("FAIL rel_swap_data got len=%0d sh=%h want 2/0201", payload_len, shadow[15:0]);
        end
        read(8'd1, d);
        n_vec++;
        if (d !== 8'h02) begin
            n_err++; $display("FAIL rel_swap_read1 got %h want 02", d);
        end
        read(8'd40, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL read_oob got %h want 00", d);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        send(8'hD5, 0); send(8'h03, 0); send(8'hAA, 0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_busy got %0b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || buffer_valid !== 1'b0 || payload_len !== 8'd0 || buffer_data !== 8'h00) begin
            n_err++; $display("FAIL mid_reset got busy=%0b valid=%0b len=%0d data=%h want 0/0/0/00",
                              busy, buffer_valid, payload_len, buffer_data);
        end
        pulses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (packet_done || packet_error || packet_overrun) pulses++;
        end
        n_vec++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_no_pulse got pulses=%0d busy=%0b want 0/0", pulses, busy);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        send(8'hD5, 0); send(8'h03, 0); send(8'hAA, 0);
`ifdef S3G_RX_TIMEOUT_EN
        cyc = 0;
        while (packet_error !== 1'b1 && cyc < 3 * TIMEOUT_CYC) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != TIMEOUT_CYC) begin
            n_err++; $display("FAIL timeout_cycles got %0d want %0d", cyc, TIMEOUT_CYC);
        end
        n_vec++;
        if (error_code !== 2'd3 || busy !== 1'b0) begin
            n_err++; $display("FAIL timeout_code got code=%0d busy=%0b want 3/0", error_code, busy);
        end
`else
        cyc = 0;
        repeat (2 * TIMEOUT_CYC) begin
            @(negedge clk);
            if (packet_error) cyc++;
        end
        n_vec++;
        if (cyc != 0 || busy !== 1'b1 || error_code === 2'd3) begin
            n_err++; $display("FAIL no_timeout got errs=%0d busy=%0b code=%0d want 0/1/not3",
                              cyc, busy, error_code);
        end
`endif
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        rx_data        = 8'h00;
        rx_done        = 1'b0;
        buffer_release = 1'b0;
        buffer_addr    = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_good_one();
        test_zero_len();
        test_crc_error();
        test_len_error();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
